sram_access_seq: RTL and testbench

//  Physical-side bus sequencer downstream of the memory mapper. Takes the 24-bit

---
 rtl/sram_access_seq.sv | 149 ++++++++++++++
 tb/tb_sram_access_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_seq.sv
// sram_access_seq: runs one async-SRAM bus cycle per mapped CPU request.
// The CPU is stretched with rdy for the duration of the access. Writes to a
// write-protected page never reach the SRAM pins; they raise a one-cycle
// wpfault_o and record the offending physical address in fault_adr.
//
// Optional build macro: SRAM_SEQ_FAULT_COUNT_EN adds an 8-bit saturating
// counter of blocked writes on port fault_cnt.
//
// state  | meaning
// IDLE   | waiting for vma; rdy high while vma is low
// SETUP  | address/data on pins, ce_n low, strobes still high
// STROBE | oe_n or we_n low for pWaitStates+1 cycles
// DONE   | strobes released, rdy high; write data still driven for hold
module sram_access_seq #(
    parameter int pWaitStates = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vma,
    input  logic        rw_n,
    input  logic [23:0] padr_i,
    input  logic        wp_i,
    input  logic [7:0]  dbi,
    output logic [7:0]  dbo,
    output logic        rdy,
    output logic [23:0] sram_a,
    input  logic [7:0]  sram_d_i,
    output logic [7:0]  sram_d_o,
    output logic        sram_d_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        wpfault_o,
    output logic [23:0] fault_adr
`ifdef SRAM_SEQ_FAULT_COUNT_EN
    ,
    output logic [7:0]  fault_cnt
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] WAIT_LOAD = 4'(pWaitStates);

    logic [1:0]  r_state;
    logic [3:0]  r_wait_cnt;
    logic        r_rw_n;
    logic [7:0]  r_dbo;
    logic [23:0] r_sram_a;
    logic [7:0]  r_sram_d_o;
    logic        r_sram_d_oe;
    logic        r_wpfault;
    logic [23:0] r_fault_adr;

    logic        w_idle;
    logic        w_block;
    logic        w_accept;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_block  = w_idle & vma & ~rw_n & wp_i;
    assign w_accept = w_idle & vma & (rw_n | ~wp_i);

    // Sequencer state, latched request and captured read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 4'd0;
            r_rw_n      <= 1'b1;
            r_dbo       <= 8'd0;
            r_sram_a    <= 24'd0;
            r_sram_d_o  <= 8'd0;
            r_sram_d_oe <= 1'b0;
            r_wpfault   <= 1'b0;
            r_fault_adr <= 24'd0;
        end else begin
            r_wpfault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_SETUP;
                        r_sram_a    <= padr_i;
                        r_sram_d_o  <= dbi;
                        r_rw_n      <= rw_n;
                        r_sram_d_oe <= ~rw_n;
                    end else if (w_block) begin
                        // Protected write: skip the SRAM entirely
                        r_state     <= ST_DONE;
                        r_wpfault   <= 1'b1;
                        r_fault_adr <= padr_i;
                    end
                end
                ST_SETUP: begin
                    r_wait_cnt <= WAIT_LOAD;
                    r_state    <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (r_wait_cnt != 4'd0) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end else begin
                        r_state <= ST_DONE;
                        if (r_rw_n) begin
                            r_dbo <= sram_d_i;
                        end
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_sram_d_oe <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_sram_d_oe <= 1'b0;
                end
            endcase
        end
    end

`ifdef SRAM_SEQ_FAULT_COUNT_EN
    logic [7:0] r_fault_cnt;

    // Saturating count of blocked writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fault_cnt <= 8'd0;
        end else if (w_block && (r_fault_cnt != 8'hFF)) begin
            r_fault_cnt <= r_fault_cnt + 8'd1;
        end
    end

    assign fault_cnt = r_fault_cnt;
`endif

    // Strobes decode straight from state so an async reset releases them at once
    assign sram_ce_n = ~((r_state == ST_SETUP) | (r_state == ST_STROBE));
    assign sram_oe_n = ~((r_state == ST_STROBE) & r_rw_n);
    assign sram_we_n = ~((r_state == ST_STROBE) & ~r_rw_n);
    assign rdy       = (r_state == ST_DONE) | (w_idle & ~vma);

    assign dbo       = r_dbo;
    assign sram_a    = r_sram_a;
    assign sram_d_o  = r_sram_d_o;
    assign sram_d_oe = r_sram_d_oe;
    assign wpfault_o = r_wpfault;
    assign fault_adr = r_fault_adr;

endmodule

// File: tb/tb_sram_access_seq.sv
// Bench for sram_access_seq: driver issues requests and pushes the expected
// response into a scoreboard; a monitor pops and compares on each handshake.
module tb_sram_access_seq;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vma;
    logic        rw_n;
    logic [23:0] padr_i;
    logic        wp_i;
    logic [7:0]  dbi;
    logic [7:0]  dbo;
    logic        rdy;
    logic [23:0] sram_a;
    logic [7:0]  sram_d_i = 8'h00;
    logic [7:0]  sram_d_o;
    logic        sram_d_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        wpfault_o;
    logic [23:0] fault_adr;
`ifdef SRAM_SEQ_FAULT_COUNT_EN
    logic [7:0]  fault_cnt;
`endif

    sram_access_seq #(.pWaitStates(WS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vma       (vma),
        .rw_n      (rw_n),
        .padr_i    (padr_i),
        .wp_i      (wp_i),
        .dbi       (dbi),
        .dbo       (dbo),
        .rdy       (rdy),
        .sram_a    (sram_a),
        .sram_d_i  (sram_d_i),
        .sram_d_o  (sram_d_o),
        .sram_d_oe (sram_d_oe),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .wpfault_o (wpfault_o),
        .fault_adr (fault_adr)
`ifdef SRAM_SEQ_FAULT_COUNT_EN
        ,
        .fault_cnt (fault_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected response of one request (kind 0=read, 1=write, 2=blocked write)
    typedef struct {
        int          kind;
        logic [23:0] addr;
        logic [7:0]  data;
        int          lat;
        int          issue;
        logic [7:0]  exp_dbo;
        logic [23:0] exp_fadr;
        int          exp_fcnt;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [7:0]  ref_mem [int];
    logic [7:0]  ref_last_rd;
    logic [23:0] ref_last_fault;
    int          ref_fcnt;
    logic [23:0] pool [16];

    // SRAM device model; drives junk when not output-enabled
    logic [7:0] sram_mem [int];
    always @(negedge clk) begin
        if (!sram_we_n && sram_d_oe) sram_mem[int'(sram_a)] = sram_d_o;
        if (!sram_oe_n)
            sram_d_i = sram_mem.exists(int'(sram_a)) ? sram_mem[int'(sram_a)] : 8'h00;
        else
            sram_d_i = 8'h5A;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: accumulates pin activity, compares on vma&rdy handshake
    bit   mon_en = 1'b0;
    int   a_ce, a_oe, a_we, a_doe, a_wpf;
    exp_t m_e;
    always @(negedge clk) begin
        if (mon_en) begin
            a_ce  += sram_ce_n ? 0 : 1;
            a_oe  += sram_oe_n ? 0 : 1;
            a_we  += sram_we_n ? 0 : 1;
            a_doe += sram_d_oe ? 1 : 0;
            a_wpf += wpfault_o ? 1 : 0;
            if (vma && rdy) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_handshake", 32'd1, 32'd0);
                end else begin
                    m_e = sb.pop_front();
                    chk("latency", 32'(cyc - m_e.issue), 32'(m_e.lat));
                    chk("dbo", 32'(dbo), 32'(m_e.exp_dbo));
                    chk("fault_adr", 32'(fault_adr), 32'(m_e.exp_fadr));
                    chk("ce_cycles", 32'(a_ce), (m_e.kind == 2) ? 32'd0 : 32'(WS + 2));
                    chk("oe_cycles", 32'(a_oe), (m_e.kind == 0) ? 32'(WS + 1) : 32'd0);
                    chk("we_cycles", 32'(a_we), (m_e.kind == 1) ? 32'(WS + 1) : 32'd0);
                    chk("doe_cycles", 32'(a_doe), (m_e.kind == 1) ? 32'(WS + 3) : 32'd0);
                    chk("wpfault_cycles", 32'(a_wpf), (m_e.kind == 2) ? 32'd1 : 32'd0);
                    if (m_e.kind != 2) chk("sram_a", 32'(sram_a), 32'(m_e.addr));
                    if (m_e.kind == 1) chk("sram_d_o", 32'(sram_d_o), 32'(m_e.data));
`ifdef SRAM_SEQ_FAULT_COUNT_EN
                    chk("fault_cnt", 32'(fault_cnt), 32'(m_e.exp_fcnt));
`endif
                end
                a_ce = 0; a_oe = 0; a_we = 0; a_doe = 0; a_wpf = 0;
            end
        end
    end

    task automatic clr_acc();
        a_ce = 0; a_oe = 0; a_we = 0; a_doe = 0; a_wpf = 0;
    endtask

    task automatic idle1();
        vma = 1'b0;
        padr_i = 24'($urandom);
        @(negedge clk); #1;
    endtask

    // Issue one request at negedge+1 and hold vma until rdy; vma left high on return
    task automatic do_req(input int kind, input logic [23:0] addr, input logic [7:0] data,
                          input bit b2b, input bit perturb);
        exp_t e;
        bit   seen;
        vma    = 1'b1;
        rw_n   = (kind == 0);
        wp_i   = (kind == 2) ? 1'b1 : ((kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
        padr_i = addr;
        dbi    = data;
        e.kind = kind; e.addr = addr; e.data = data;
        case (kind)
            0: begin
                ref_last_rd = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 8'h00;
            end
            1: ref_mem[int'(addr)] = data;
            default: begin
                ref_last_fault = addr;
                if (ref_fcnt < 255) ref_fcnt++;
            end
        endcase
        e.exp_dbo  = ref_last_rd;
        e.exp_fadr = ref_last_fault;
        e.exp_fcnt = ref_fcnt;
        e.lat      = ((kind == 2) ? 1 : WS + 3) + (b2b ? 1 : 0);
        e.issue    = cyc;
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk); #1;
            if (rdy) seen = 1'b1;
            else if (perturb && i >= (b2b ? 1 : 0)) begin
                padr_i = 24'($urandom);
                dbi    = 8'($urandom);
                rw_n   = 1'($urandom);
                wp_i   = 1'($urandom);
            end
        end
        if (!seen) chk("rdy_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int ce_cnt;
        int oe_cnt;
        logic [7:0] exp_rd;
        logic [23:0] a;

        reset_n = 1'b0; vma = 1'b0; rw_n = 1'b1; wp_i = 1'b0; padr_i = 24'd0; dbi = 8'd0;
        pool[0] = 24'h012345;
        for (int k = 1; k < 16; k++) begin
            pool[k] = 24'($urandom);
            if (pool[k] == 24'hABCDEF || pool[k] == 24'h012345) pool[k] = 24'(k);
        end
        for (int k = 0; k < 16; k++) begin
            ref_mem[int'(pool[k])]  = 8'($urandom);
            sram_mem[int'(pool[k])] = ref_mem[int'(pool[k])];
        end
        ref_mem[int'(24'h012345)]  = 8'hA5;
        sram_mem[int'(24'h012345)] = 8'hA5;
        ref_last_rd = 8'h00; ref_last_fault = 24'd0; ref_fcnt = 0;

        repeat (3) @(negedge clk);
        chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_d_oe", 32'(sram_d_oe), 32'd0);
        chk("rst_dbo", 32'(dbo), 32'd0);
        chk("rst_sram_a", 32'(sram_a), 32'd0);
        chk("rst_sram_d_o", 32'(sram_d_o), 32'd0);
        chk("rst_wpfault", 32'(wpfault_o), 32'd0);
        chk("rst_fault_adr", 32'(fault_adr), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd1);
`ifdef SRAM_SEQ_FAULT_COUNT_EN
        chk("rst_fault_cnt", 32'(fault_cnt), 32'd0);
`endif
        #1 reset_n = 1'b1;
        @(negedge clk); #1;
        clr_acc();
        mon_en = 1'b1;

        do_req(0, 24'h012345, 8'h00, 1'b0, 1'b0);
        idle1();
        do_req(1, pool[1], 8'h3C, 1'b0, 1'b0);
        idle1();
        do_req(2, 24'hFFF800, 8'($urandom), 1'b0, 1'b0);
        idle1();

        for (int n = 0; n < 80; n++) begin
            bit b2b;
            kind = $urandom_range(0, 99);
            kind = (kind < 40) ? 0 : ((kind < 75) ? 1 : 2);
            b2b  = ($urandom_range(0, 3) == 0);
            if (!b2b) idle1();
            do_req(kind, pool[$urandom_range(0, 15)], 8'($urandom), b2b, 1'($urandom));
        end
        idle1();
        idle1();
        chk("sb_empty_random", 32'(sb.size()), 32'd0);

        // vma dropped during SETUP: access still completes once, no repeat
        mon_en = 1'b0;
        a = pool[5];
        exp_rd = ref_mem[int'(a)];
        ref_last_rd = exp_rd;
        vma = 1'b1; rw_n = 1'b1; wp_i = 1'b0; padr_i = a;
        ce_cnt = 0; oe_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ce_cnt += sram_ce_n ? 0 : 1;
            oe_cnt += sram_oe_n ? 0 : 1;
            #1;
            if (i == 0) begin
                vma = 1'b0; padr_i = 24'($urandom); rw_n = 1'b0;
            end
        end
        chk("drop_ce_cycles", 32'(ce_cnt), 32'(WS + 2));
        chk("drop_oe_cycles", 32'(oe_cnt), 32'(WS + 1));
        chk("drop_dbo", 32'(dbo), 32'(exp_rd));

        // Reset asserted mid-STROBE on a write
        vma = 1'b1; rw_n = 1'b0; wp_i = 1'b0; padr_i = 24'hABCDEF; dbi = 8'h77;
        @(negedge clk); #1;
        vma = 1'b0;
        @(negedge clk); #1;
        chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        chk("pre_rst_d_oe", 32'(sram_d_oe), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_ce_n", 32'(sram_ce_n), 32'd1);
        chk("async_rst_we_n", 32'(sram_we_n), 32'd1);
        chk("async_rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("async_rst_d_oe", 32'(sram_d_oe), 32'd0);
        chk("async_rst_dbo", 32'(dbo), 32'd0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        ref_last_rd = 8'h00; ref_last_fault = 24'd0; ref_fcnt = 0;
        @(negedge clk);
        chk("post_rst_rdy", 32'(rdy), 32'd1);
        chk("post_rst_ce_n", 32'(sram_ce_n), 32'd1);
        #1;
        clr_acc();
        mon_en = 1'b1;
        do_req(0, pool[0], 8'h00, 1'b0, 1'b0);
        idle1();
        do_req(2, pool[7], 8'h00, 1'b0, 1'b0);
        idle1();

`ifdef SRAM_SEQ_FAULT_COUNT_EN
        for (int n = 0; n < 300; n++) begin
            idle1();
            do_req(2, 24'($urandom), 8'($urandom), 1'b0, 1'b0);
        end
        idle1();
        chk("fault_cnt_saturated", 32'(fault_cnt), 32'hFF);
`endif

        idle1();
        idle1();
        chk("sb_empty_final", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
